nonce_readout: RTL
==================

NONCE_READOUT -- requirements
Module: nonce_readout

Interface
REQ-001 The block SHALL have these ports:
- clk, in, 1: single rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- nonce1_in, in, 40: ping-pong slot 1 record, {3'b0, success, hash_id[3:0], nonce[31:0]}.
- nonce2_in, in, 40: ping-pong slot 2 record, same format.
- nonce_mark_counter, in, 2: count of records captured but not yet consumed.
- byte_out, out, 8: serialized record byte.
- byte_valid, out, 1: byte_out is valid.
- byte_ready, in, 1: the downstream sink accepts byte_out.
- data_gen_st, out, 4: current state code, which the capture side decodes.
- rd_mark, out, 1: slot to read next (0 = slot 1, 1 = slot 2).
- overrun, out, 1: sticky flag, pending count reached 3.
REQ-002 Parameter BYTES_PER_REC SHALL default to 5 and gives the number of bytes in one 40-bit record.

Function
REQ-003 The state codes SHALL be: IDLE=0000, LATCH=0001, SEND=0011, ACK=0110, GAP=0100.
REQ-004 Code 0111 SHALL never be driven, and ACK SHALL be the only state encoded 0110.
REQ-005 IDLE SHALL go to LATCH when nonce_mark_counter != 0, and otherwise stay in IDLE.
REQ-006 LATCH SHALL load the 40-bit shift register from nonce1_in if rd_mark=0, else from nonce2_in, clear the byte index, and go to SEND; it lasts one cycle.
REQ-007 SEND SHALL assert byte_valid=1 with byte_out = shift register bits [39:32], which is the most significant byte first.
REQ-008 In SEND, on valid&&ready the block SHALL shift left by 8 and increment the byte index; after the byte with index BYTES_PER_REC-1 is accepted it SHALL go to ACK.
REQ-009 While byte_valid=1 and byte_ready=0, byte_out SHALL be held stable and byte_valid SHALL NOT drop.
REQ-010 ACK SHALL last exactly one cycle, drive byte_valid=0, toggle rd_mark, and go to GAP.
REQ-011 GAP SHALL last exactly one cycle and then go to IDLE, so that the capture side's registered decrement is visible before the counter is re-sampled.
REQ-012 Exactly one cycle with data_gen_st=0110 SHALL occur per transmitted record.
REQ-013 Latency from IDLE sampling a nonzero counter to the first byte_valid=1 SHALL be 2 cycles (IDLE to LATCH, LATCH to SEND).
REQ-014 Minimum record period with byte_ready held at 1 SHALL be 1+1+5+1+1 = 9 cycles (IDLE, LATCH, 5 SEND, ACK, GAP).
REQ-015 overrun SHALL set on any cycle with nonce_mark_counter==2'b11 and clear only on reset.
REQ-016 When overrun is set, transmission SHALL continue normally.
REQ-017 A counter change during LATCH, SEND, ACK or GAP SHALL have no effect until the next IDLE.
REQ-018 An undefined state code SHALL recover to IDLE on the next cycle with byte_valid=0.

Reset
REQ-019 While reset=1 at a clk edge, the following SHALL be cleared on that edge: state to IDLE, byte_out=0, byte_valid=0, rd_mark=0, overrun=0, shift register=0, byte index=0.
REQ-020 A reset during SEND SHALL abort the record without an ACK cycle, leaving the counter undecremented, and byte_valid=0 from that edge onward.

Structure
REQ-021 A shared package nonce_pkg SHALL hold the state codes, the record width (40), BYTES_PER_REC, and the record field offsets (success bit 36, hash_id [35:32]).
REQ-022 Sub-module nonce_byte_serializer (40-bit load, shift-by-8, byte index, last-byte flag) SHALL be instantiated once; the FSM stays in nonce_readout.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Counter=1, slot1=40'h19_DEADBEEF, ready=1: bytes 19,DE,AD,BE,EF on consecutive cycles; first valid 2 cycles after IDLE sampling; one 0110 cycle; rd_mark changes 0 to 1.
- Counter=2 held, slot1=40'h01_00000001, slot2=40'h12_CAFEF00D: slot1 bytes then slot2 bytes; two ACK pulses; rd_mark ends at 0.
- Ready toggled 1,0,0,1,... during SEND: byte_out and byte_valid held through each stall; all 5 bytes delivered exactly once, in order.
- Counter forced to 3 for one cycle: overrun=1 and stays 1; transmission unaffected.
- Reset asserted after the 2nd byte is accepted: next edge gives byte_valid=0, state 0000, rd_mark=0, no 0110 cycle; after release with counter=1, the full record is resent from byte 0.
- Full run: data_gen_st never equals 0111; count of 0110 cycles equals the number of records sent.

Source files
------------

// File: rtl/nonce_pkg.sv
// Shared definitions for the nonce readout path: record layout, byte count and
// the state codes that the capture side decodes.
package nonce_pkg;

  localparam int REC_W         = 40;
  localparam int BYTES_PER_REC = 5;
  localparam int SUCCESS_BIT   = 36;
  localparam int HASH_ID_MSB   = 35;
  localparam int HASH_ID_LSB   = 32;

  // 4'b0111 is deliberately left unused; the capture side treats 4'b0110 as the
  // one-cycle consume strobe.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_LATCH = 4'b0001,
    ST_SEND  = 4'b0011,
    ST_ACK   = 4'b0110,
    ST_GAP   = 4'b0100
  } gen_state_e;

endpackage

// File: rtl/nonce_byte_serializer.sv
// 40-bit record shifter: parallel load, MSB-first byte presentation, shift by
// one byte per accepted transfer, and a flag marking the final byte.
module nonce_byte_serializer #(
  parameter int BYTES_PER_REC = nonce_pkg::BYTES_PER_REC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_i,
  input  logic [nonce_pkg::REC_W-1:0]  data_i,
  input  logic                         shift_i,
  output logic [7:0]                   byte_o,
  output logic                         last_o
);
  import nonce_pkg::*;

  localparam int IDX_W = (BYTES_PER_REC > 1) ? $clog2(BYTES_PER_REC) : 1;

  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[REC_W-9:0], 8'h00};
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shreg_q[REC_W-1 -: 8];
  assign last_o = (idx_q == IDX_W'(BYTES_PER_REC - 1));

endmodule

// File: rtl/nonce_readout.sv
// Reads captured nonce records out of a two-slot ping-pong buffer and streams
// each one as BYTES_PER_REC bytes over a valid/ready byte interface.
module nonce_readout #(
  parameter int BYTES_PER_REC = nonce_pkg::BYTES_PER_REC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] nonce1_in,
  input  logic [39:0] nonce2_in,
  input  logic [1:0]  nonce_mark_counter,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [3:0]  data_gen_st,
  output logic        rd_mark,
  output logic        overrun
);
  import nonce_pkg::*;

  gen_state_e state_q, state_d;
  logic       rd_mark_q, rd_mark_d;
  logic       overrun_q, overrun_d;
  logic       ser_load, ser_shift, ser_last;

  always_comb begin
    state_d    = state_q;
    rd_mark_d  = rd_mark_q;
    overrun_d  = overrun_q | (nonce_mark_counter == 2'b11);
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    byte_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nonce_mark_counter != 2'b00) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          ser_shift = 1'b1;
          if (ser_last) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        rd_mark_d = ~rd_mark_q;
        state_d   = ST_GAP;
      end
      // GAP lets the capture side's registered decrement land before IDLE
      // looks at the counter again.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_mark_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_mark_q <= rd_mark_d;
      overrun_q <= overrun_d;
    end
  end

  nonce_byte_serializer #(
    .BYTES_PER_REC(BYTES_PER_REC)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ser_load),
    .data_i  (rd_mark_q ? nonce2_in : nonce1_in),
    .shift_i (ser_shift),
    .byte_o  (byte_out),
    .last_o  (ser_last)
  );

  assign data_gen_st = state_q;
  assign rd_mark     = rd_mark_q;
  assign overrun     = overrun_q;

endmodule
